// File: rtl/vga_timing_pkg.sv
// Shared constants and types for the 640x480@60 VGA raster generator.
// The optional VGA_TIMING_SYNC_PIPE_EN stage is configured in vga_timing_gen.
package vga_timing_pkg;

   localparam int unsigned H_VISIBLE = 640;
   localparam int unsigned H_FRONT   = 16;
   localparam int unsigned H_SYNC    = 96;
   localparam int unsigned H_BACK    = 48;
   localparam int unsigned V_VISIBLE = 480;
   localparam int unsigned V_FRONT   = 10;
   localparam int unsigned V_SYNC    = 2;
   localparam int unsigned V_BACK    = 33;

   localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   typedef logic [9:0]  coord_t;
   typedef logic [15:0] frame_cnt_t;

   typedef struct packed {
      logic hs;
      logic vs;
      logic blank;
      logic frame_start;
   } sync_t;

   localparam sync_t SYNC_RST = '{hs: 1'b1, vs: 1'b1, blank: 1'b0, frame_start: 1'b0};

   // Half-open window test used for both sync pulses.
   function automatic logic in_window(coord_t v, coord_t lo, coord_t hi);
      return (v >= lo) && (v < hi);
   endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster bus from the timing generator (master) to renderers and palette stages (slave).
interface vga_timing_gen_if;
   import vga_timing_pkg::*;

   logic       hs;
   logic       vs;
   logic       blank;
   coord_t     DrawX;
   coord_t     DrawY;
   logic       frame_start;
   frame_cnt_t frame_count;

   modport master (
      output hs, vs, blank, DrawX, DrawY, frame_start, frame_count
   );

   modport slave (
      input hs, vs, blank, DrawX, DrawY, frame_start, frame_count
   );
endinterface

// File: rtl/vga_axis_counter.sv
// Wrapping 0..TOTAL-1 counter with enable; o_carry flags the terminal count
// so the next axis can step on the same enabled edge.
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int unsigned TOTAL = 800
)(
   input  logic   i_clk,
   input  logic   i_rst,
   input  logic   i_en,
   output coord_t o_cnt,
   output logic   o_carry
);

   coord_t r_cnt;

   assign o_carry = (r_cnt == coord_t'(TOTAL - 1));
   assign o_cnt   = r_cnt;

   // counter state: step on enable, wrap after the terminal count
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt <= 10'd0;
      end else if (i_en) begin
         if (o_carry) begin
            r_cnt <= 10'd0;
         end else begin
            r_cnt <= r_cnt + 10'd1;
         end
      end
   end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: h/v counters, registered sync/blank/coordinate decode, frame strobes.
// Define VGA_TIMING_SYNC_PIPE_EN to delay hs/vs/blank/frame_start one more enabled cycle.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int unsigned P_H_VISIBLE = H_VISIBLE,
   parameter int unsigned P_H_FRONT   = H_FRONT,
   parameter int unsigned P_H_SYNC    = H_SYNC,
   parameter int unsigned P_H_BACK    = H_BACK,
   parameter int unsigned P_V_VISIBLE = V_VISIBLE,
   parameter int unsigned P_V_FRONT   = V_FRONT,
   parameter int unsigned P_V_SYNC    = V_SYNC,
   parameter int unsigned P_V_BACK    = V_BACK
)(
   input  logic              vga_clk,
   input  logic              reset,
   input  logic              pix_ce,
   vga_timing_gen_if.master  vga
);

   localparam int unsigned H_TOT = P_H_VISIBLE + P_H_FRONT + P_H_SYNC + P_H_BACK;
   localparam int unsigned V_TOT = P_V_VISIBLE + P_V_FRONT + P_V_SYNC + P_V_BACK;

   localparam coord_t H_VIS_C = coord_t'(P_H_VISIBLE);
   localparam coord_t V_VIS_C = coord_t'(P_V_VISIBLE);
   localparam coord_t HS_LO   = coord_t'(P_H_VISIBLE + P_H_FRONT);
   localparam coord_t HS_HI   = coord_t'(P_H_VISIBLE + P_H_FRONT + P_H_SYNC);
   localparam coord_t VS_LO   = coord_t'(P_V_VISIBLE + P_V_FRONT);
   localparam coord_t VS_HI   = coord_t'(P_V_VISIBLE + P_V_FRONT + P_V_SYNC);

   coord_t     w_h_cnt;
   coord_t     w_v_cnt;
   logic       w_h_carry;
   logic       w_v_carry;
   logic       w_v_en;
   logic       w_frame_wrap;
   sync_t      w_sync;
   sync_t      w_sync_out;

   coord_t     r_draw_x;
   coord_t     r_draw_y;
   sync_t      r_sync;
   frame_cnt_t r_frame_cnt;
   frame_cnt_t r_frame_out;

   assign w_v_en       = pix_ce & w_h_carry;
   assign w_frame_wrap = w_v_en & w_v_carry;

   vga_axis_counter #(.TOTAL(H_TOT)) u_h_cnt (
      .i_clk   (vga_clk),
      .i_rst   (reset),
      .i_en    (pix_ce),
      .o_cnt   (w_h_cnt),
      .o_carry (w_h_carry)
   );

   vga_axis_counter #(.TOTAL(V_TOT)) u_v_cnt (
      .i_clk   (vga_clk),
      .i_rst   (reset),
      .i_en    (w_v_en),
      .o_cnt   (w_v_cnt),
      .o_carry (w_v_carry)
   );

   // sync/blank/frame_start decode from the current counters
   always_comb begin
      w_sync             = SYNC_RST;
      w_sync.blank       = (w_h_cnt < H_VIS_C) && (w_v_cnt < V_VIS_C);
      w_sync.hs          = ~in_window(w_h_cnt, HS_LO, HS_HI);
      w_sync.vs          = ~in_window(w_v_cnt, VS_LO, VS_HI);
      w_sync.frame_start = (w_h_cnt == 10'd0) && (w_v_cnt == 10'd0);
   end

   // completed-frame count advances when the raster wraps back to 0,0
   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
         r_frame_cnt <= 16'd0;
      end else if (w_frame_wrap) begin
         r_frame_cnt <= r_frame_cnt + 16'd1;
      end
   end

   // output registers: one enabled cycle behind the counters
   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
         r_draw_x    <= 10'd0;
         r_draw_y    <= 10'd0;
         r_sync      <= SYNC_RST;
         r_frame_out <= 16'd0;
      end else if (pix_ce) begin
         r_draw_x    <= w_h_cnt;
         r_draw_y    <= w_v_cnt;
         r_sync      <= w_sync;
         r_frame_out <= r_frame_cnt;
      end
   end

`ifdef VGA_TIMING_SYNC_PIPE_EN
   sync_t r_sync_d;

   // extra stage lines sync/blank up with colour registered after the ROM read
   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
         r_sync_d <= SYNC_RST;
      end else if (pix_ce) begin
         r_sync_d <= r_sync;
      end
   end

   assign w_sync_out = r_sync_d;
`else
   assign w_sync_out = r_sync;
`endif

   assign vga.DrawX       = r_draw_x;
   assign vga.DrawY       = r_draw_y;
   assign vga.hs          = w_sync_out.hs;
   assign vga.vs          = w_sync_out.vs;
   assign vga.blank       = w_sync_out.blank;
   assign vga.frame_start = w_sync_out.frame_start;
   assign vga.frame_count = r_frame_out;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: full-size raster plus a miniature raster for frame-level behaviour.
module tb_vga_timing_gen;
   import vga_timing_pkg::*;

`ifdef VGA_TIMING_SYNC_PIPE_EN
   localparam int PIPE = 1;
`else
   localparam int PIPE = 0;
`endif

   typedef struct packed {
      logic [9:0]  x;
      logic [9:0]  y;
      logic        blank;
      logic        hs;
      logic        vs;
      logic        fs;
      logic [15:0] fc;
   } exp_t;

   localparam exp_t RST = '{x: 10'd0, y: 10'd0, blank: 1'b0, hs: 1'b1, vs: 1'b1, fs: 1'b0, fc: 16'd0};

   // geometry: index 0 = full VGA, index 1 = 16x10 miniature raster
   localparam int HV [2] = '{H_VISIBLE, 8};
   localparam int HF [2] = '{H_FRONT, 2};
   localparam int HSW[2] = '{H_SYNC, 3};
   localparam int HB [2] = '{H_BACK, 3};
   localparam int VV [2] = '{V_VISIBLE, 6};
   localparam int VF [2] = '{V_FRONT, 1};
   localparam int VSW[2] = '{V_SYNC, 2};
   localparam int VB [2] = '{V_BACK, 1};

   logic vga_clk = 1'b0;
   logic reset   = 1'b1;
   logic pix_ce  = 1'b0;

   int checks   = 0;
   int failures = 0;

   exp_t q0[$];
   exp_t q1[$];
   int   mh[2];
   int   mv[2];
   int   mfc[2];
   exp_t prev[2];

   logic track = 1'b0;
   int   first_hs_x = -1;
   int   hs_low_cnt = 0;
   int   blank_fall_x = -1;
   logic seen_blank1 = 1'b0;
   int   edge_idx = 0;
   int   fs_pos0 = -1;
   int   fs_pos1 = -1;
   int   vs_low_cnt = 0;

   vga_timing_gen_if if0();
   vga_timing_gen_if if1();

   vga_timing_gen u_big (
      .vga_clk (vga_clk),
      .reset   (reset),
      .pix_ce  (pix_ce),
      .vga     (if0)
   );

   vga_timing_gen #(
      .P_H_VISIBLE(8), .P_H_FRONT(2), .P_H_SYNC(3), .P_H_BACK(3),
      .P_V_VISIBLE(6), .P_V_FRONT(1), .P_V_SYNC(2), .P_V_BACK(1)
   ) u_small (
      .vga_clk (vga_clk),
      .reset   (reset),
      .pix_ce  (pix_ce),
      .vga     (if1)
   );

   always #5 vga_clk = ~vga_clk;

   function automatic exp_t act(int d);
      exp_t a;
      if (d == 0) a = '{x: if0.DrawX, y: if0.DrawY, blank: if0.blank, hs: if0.hs, vs: if0.vs, fs: if0.frame_start, fc: if0.frame_count};
      else        a = '{x: if1.DrawX, y: if1.DrawY, blank: if1.blank, hs: if1.hs, vs: if1.vs, fs: if1.frame_start, fc: if1.frame_count};
      return a;
   endfunction

   task automatic cmp(input string tag, input exp_t a, input exp_t e);
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL %s: got x=%0d y=%0d blank=%b hs=%b vs=%b fs=%b fc=%0d, want x=%0d y=%0d blank=%b hs=%b vs=%b fs=%b fc=%0d",
                  tag, a.x, a.y, a.blank, a.hs, a.vs, a.fs, a.fc, e.x, e.y, e.blank, e.hs, e.vs, e.fs, e.fc);
      end
   endtask

   task automatic chk_int(input string tag, input int a, input int e);
      checks++;
      if (a != e) begin
         failures++;
         $display("FAIL %s: got %0d, want %0d", tag, a, e);
      end
   endtask

   function automatic exp_t model_out(int d, int h, int v, int fc);
      exp_t e;
      e.x     = h[9:0];
      e.y     = v[9:0];
      e.blank = (h < HV[d]) && (v < VV[d]);
      e.hs    = !((h >= HV[d] + HF[d]) && (h < HV[d] + HF[d] + HSW[d]));
      e.vs    = !((v >= VV[d] + VF[d]) && (v < VV[d] + VF[d] + VSW[d]));
      e.fs    = (h == 0) && (v == 0);
      e.fc    = fc[15:0];
      return e;
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         mh[d] = 0; mv[d] = 0; mfc[d] = 0; prev[d] = RST;
      end
   endtask

   // one clock of stimulus; an enabled edge queues the expected outputs
   task automatic step(input logic ce);
      exp_t e;
      exp_t o;
      @(negedge vga_clk);
      pix_ce = ce;
      if (ce) begin
         for (int d = 0; d < 2; d++) begin
            e = model_out(d, mh[d], mv[d], mfc[d]);
            o = e;
            if (PIPE == 1) begin
               o.hs = prev[d].hs; o.vs = prev[d].vs; o.blank = prev[d].blank; o.fs = prev[d].fs;
               prev[d] = e;
            end
            if (d == 0) q0.push_back(o); else q1.push_back(o);
            if (mh[d] == HV[d] + HF[d] + HSW[d] + HB[d] - 1) begin
               mh[d] = 0;
               if (mv[d] == VV[d] + VF[d] + VSW[d] + VB[d] - 1) begin
                  mv[d] = 0;
                  mfc[d] = (mfc[d] + 1) % 65536;
               end else begin
                  mv[d]++;
               end
            end else begin
               mh[d]++;
            end
         end
      end
   endtask

   // monitor: compare on enabled edges, check hold on disabled ones
   initial begin : monitor
      exp_t last0;
      exp_t last1;
      exp_t e;
      exp_t a;
      logic s_ce;
      logic s_rst;
      last0 = RST;
      last1 = RST;
      forever begin
         @(posedge vga_clk);
         s_ce  = pix_ce;
         s_rst = reset;
         #1;
         if (s_rst) begin
            last0 = RST;
            last1 = RST;
         end else if (s_ce) begin
            if (q0.size() == 0 || q1.size() == 0) begin
               checks++; failures++;
               $display("FAIL scoreboard_empty: got enabled edge, want queued expectation");
            end else begin
               e = q0.pop_front(); a = act(0); cmp("big_out", a, e); last0 = e;
               if (track) begin
                  if (first_hs_x < 0 && a.hs == 1'b0) first_hs_x = int'(a.x);
                  if (a.hs == 1'b0 && a.y == 10'd0) hs_low_cnt++;
                  if (a.blank == 1'b1) seen_blank1 = 1'b1;
                  if (seen_blank1 && blank_fall_x < 0 && a.blank == 1'b0) blank_fall_x = int'(a.x);
               end
               e = q1.pop_front(); a = act(1); cmp("small_out", a, e); last1 = e;
               if (track) begin
                  if (a.fs == 1'b1) begin
                     if (fs_pos0 < 0) fs_pos0 = edge_idx;
                     else if (fs_pos1 < 0) fs_pos1 = edge_idx;
                  end
                  if (fs_pos0 >= 0 && fs_pos1 < 0 && a.vs == 1'b0) vs_low_cnt++;
                  edge_idx++;
               end
            end
         end else begin
            cmp("big_hold", act(0), last0);
            cmp("small_hold", act(1), last1);
         end
      end
   end

   initial begin : driver
      int guard;
      model_reset();
      repeat (3) @(negedge vga_clk);
      cmp("big_reset", act(0), RST);
      cmp("small_reset", act(1), RST);
      @(negedge vga_clk);
      reset = 1'b0;

      // continuous: one full VGA line, five miniature frames
      track = 1'b1;
      repeat (810) step(1'b1);
      track = 1'b0;

      // half-rate enable: identical sequence, each value held two clocks
      repeat (800) begin
         step(1'b1);
         step(1'b0);
      end

      // run to DrawX=300, then assert reset between clock edges
      guard = 0;
      while (mh[0] != 301 && guard < 900) begin
         step(1'b1);
         guard++;
      end
      chk_int("reach_x300", mh[0], 301);
      @(negedge vga_clk);
      pix_ce = 1'b0;
      #2 reset = 1'b1;
      #1;
      cmp("big_async_reset", act(0), RST);
      cmp("small_async_reset", act(1), RST);
      model_reset();
      repeat (2) @(negedge vga_clk);
      reset = 1'b0;
      repeat (20) step(1'b1);
      repeat (3) step(1'b0);
      @(negedge vga_clk);

      chk_int("first_hs_low_x", first_hs_x, 656 + PIPE);
      chk_int("hs_low_width", hs_low_cnt, 96);
      chk_int("blank_fall_x", blank_fall_x, 640 + PIPE);
      chk_int("frame_start_first", fs_pos0, PIPE);
      chk_int("frame_period", fs_pos1 - fs_pos0, 160);
      chk_int("vs_low_edges", vs_low_cnt, 32);
      chk_int("big_queue_drained", q0.size(), 0);
      chk_int("small_queue_drained", q1.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
